fifo_frame_drain: RTL and testbench
===================================

Name: fifo_frame_drain

Overview:
- Downstream consumer of the switch's frame FIFO.
- Pops {last, data} words from the FIFO read port and accounts for the RAM's one-cycle read latency.
- Presents the words as a valid/ready byte stream to the egress/MAC-TX stage through a 2-entry output buffer.
- Counts bytes per frame and reports each frame's length on completion.

Parameters:
- DATA_WIDTH, 8, stream data width; FIFO word width is DATA_WIDTH+1, with bit DATA_WIDTH = last.
- LENGTH_WIDTH, 11, width of the per-frame byte counter; it saturates at 2^LENGTH_WIDTH-1.

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fifo_read_data  input  DATA_WIDTH+1  FIFO word, valid the cycle after an accepted read.
- fifo_is_empty  input  1  FIFO empty flag.
- fifo_read_enable  output  1  FIFO pop request; combinational.
- out_data  output  DATA_WIDTH  stream byte.
- out_last  output  1  marks the final byte of a frame.
- out_valid  output  1  out_data/out_last are valid.
- out_ready  input  1  sink accepts the current beat.
- frame_done  output  1  one-cycle pulse per completed frame.
- frame_length  output  LENGTH_WIDTH  byte count of the completed frame; held until the next frame_done.
- frame_overflow  output  1  completed frame hit counter saturation; valid with frame_done and held with frame_length.

Behaviour:
- Reset (reset_n low, asynchronous): buffer emptied, in-flight flag cleared, byte counter = 0.
  - out_valid=0, out_data=0, out_last=0, frame_done=0, frame_length=0, frame_overflow=0.
  - fifo_read_enable=0 while reset_n is low.
- FIFO read latency:
  - An accepted read is fifo_read_enable=1 and fifo_is_empty=0 in cycle N.
  - fifo_read_data is captured at the end of cycle N+1.
  - A 1-bit in-flight register tracks the outstanding read.
- Output buffer: 2-entry FIFO of {last, data}, occupancy count 0..2.
  - out_valid = (count != 0).
  - out_data/out_last come from the head entry.
  - The head is stable while out_valid=1 and out_ready=0.
- Pop condition, with pop = out_valid & out_ready:
  - fifo_read_enable = ~fifo_is_empty & ((count + inflight) < 2 | ((count + inflight) == 2 & pop)).
  - This guarantees count never exceeds 2, with no overrun and no data loss.
  - It sustains one beat per cycle when out_ready is held high and the FIFO is non-empty.
- Simultaneous capture and pop in the same cycle: count is unchanged and order is preserved.
  - The captured word goes behind the remaining entry, or directly to head if the buffer empties.
- Words leave in exact FIFO order. No word is duplicated or dropped.
- Frame accounting:
  - On each transfer (pop), byte_count = byte_count + 1, saturating at 2^LENGTH_WIDTH-1.
  - A sticky overflow flag is set when an increment is attempted at saturation.
  - On a transfer with out_last=1, the following cycle has:
    - frame_done=1;
    - frame_length = counter value including the last byte (saturated);
    - frame_overflow = sticky flag.
  - The counter and sticky flag clear to 0 for the next frame.
  - A last byte transferred in cycle N is counted in the frame that completes in N, even if the next frame's first byte transfers in N+1.
- Empty FIFO mid-frame: output goes invalid and the counter holds. The frame continues when data resumes; gaps are not an error.
- Reset mid-frame: all state is discarded, including the in-flight read and partial count. No frame_done is generated for the aborted frame.
  - Upstream FIFO reset is handled by the same system reset tree.
- No combinational path from out_ready to out_valid/out_data.
  - The only combinational path from out_ready is to fifo_read_enable.

Test Plan:
1. Reset, then FIFO holds 3 words {0,0x11},{0,0x22},{1,0x33}, out_ready=1 -> out_valid beats 0x11,0x22,0x33 on consecutive cycles, with the first beat 2 cycles after the first fifo_read_enable.
   - out_last only on 0x33; frame_done pulses the next cycle with frame_length=3 and frame_overflow=0.
2. Same frame with out_ready low for 5 cycles after the first beat -> 0x11 held stable throughout.
   - At most 2 FIFO reads are outstanding or buffered, fifo_read_enable=0 while the buffer is full, and no byte is lost or repeated.
3. Randomly toggle fifo_is_empty and out_ready over a 64-byte frame -> the output sequence equals the input sequence, and frame_length=64.
4. Back-to-back frames of lengths 1 and 2 with out_ready=1 -> two frame_done pulses, with frame_length=1 then 2. frame_length holds 2 afterwards.
5. LENGTH_WIDTH=4 with a 20-byte frame -> frame_length=15 and frame_overflow=1. The next 2-byte frame reports 2 with frame_overflow=0.
6. Assert reset_n low while a read is in flight mid-frame, then release -> all outputs are 0 during reset with no frame_done.
   - A fresh 3-byte frame afterwards reports frame_length=3.

Source files
------------

// File: rtl/fifo_frame_drain.sv
// fifo_frame_drain
// Pops {last, data} words from the frame FIFO and absorbs the RAM's one-cycle
// read latency. Words are presented as a valid/ready byte stream from a
// 2-entry output buffer, and each completed frame's byte count is reported.
module fifo_frame_drain #(
   parameter int DATA_WIDTH   = 8,
   parameter int LENGTH_WIDTH = 11
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [DATA_WIDTH:0]     fifo_read_data,
   input  logic                    fifo_is_empty,
   output logic                    fifo_read_enable,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    frame_done,
   output logic [LENGTH_WIDTH-1:0] frame_length,
   output logic                    frame_overflow
);

   localparam int                      WORD_WIDTH = DATA_WIDTH + 1;
   localparam logic [LENGTH_WIDTH-1:0] LEN_MAX    = {LENGTH_WIDTH{1'b1}};
   localparam logic [LENGTH_WIDTH-1:0] LEN_ZERO   = {LENGTH_WIDTH{1'b0}};
   localparam logic [LENGTH_WIDTH-1:0] LEN_ONE    = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WORD_WIDTH-1:0]   WORD_ZERO  = {WORD_WIDTH{1'b0}};

   // Output buffer: r_entry0 is always the head, r_entry1 sits behind it.
   logic [WORD_WIDTH-1:0]   r_entry0;
   logic [WORD_WIDTH-1:0]   r_entry1;
   logic [1:0]              r_count;
   logic                    r_inflight;

   // Frame accounting state.
   logic [LENGTH_WIDTH-1:0] r_byte_count;
   logic                    r_sticky_ovf;
   logic                    r_frame_done;
   logic [LENGTH_WIDTH-1:0] r_frame_length;
   logic                    r_frame_overflow;

   logic                    w_pop;
   logic                    w_capture;
   logic                    w_read_room;
   logic                    w_read_accept;
   logic [1:0]              w_occupancy;
   logic                    w_at_max;
   logic [LENGTH_WIDTH-1:0] w_count_inc;

   assign w_pop         = out_valid & out_ready;
   assign w_capture     = r_inflight;
   assign w_occupancy   = r_count + {1'b0, r_inflight};
   assign w_read_accept = ~fifo_is_empty & w_read_room;

   // Read is allowed while buffered plus in-flight words leave room, counting a same-cycle pop.
   always_comb begin
      w_read_room = 1'b0;
      if (w_occupancy < 2'd2) begin
         w_read_room = 1'b1;
      end else if (w_occupancy == 2'd2) begin
         w_read_room = w_pop;
      end else begin
         w_read_room = 1'b0;
      end
   end

   // Gate with reset only at the port so no pop request escapes during reset.
   assign fifo_read_enable = reset_n & w_read_accept;

   // Track the single outstanding read whose data arrives next cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_read_accept;
      end
   end

   // Output buffer: capture behind the remaining entry, shift on pop, keep order on both.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_entry0 <= WORD_ZERO;
         r_entry1 <= WORD_ZERO;
         r_count  <= 2'd0;
      end else begin
         case ({w_capture, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_entry0 <= fifo_read_data;
               end else begin
                  r_entry1 <= fifo_read_data;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_entry0 <= r_entry1;
               r_count  <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_entry0 <= fifo_read_data;
               end else begin
                  r_entry0 <= r_entry1;
                  r_entry1 <= fifo_read_data;
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_entry0[DATA_WIDTH-1:0];
   assign out_last  = r_entry0[DATA_WIDTH];

   // Saturating increment of the per-frame byte counter.
   always_comb begin
      w_at_max = (r_byte_count == LEN_MAX);
      if (w_at_max) begin
         w_count_inc = r_byte_count;
      end else begin
         w_count_inc = r_byte_count + LEN_ONE;
      end
   end

   // Count transferred bytes; on the last byte publish length/overflow and restart the count.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_byte_count     <= LEN_ZERO;
         r_sticky_ovf     <= 1'b0;
         r_frame_done     <= 1'b0;
         r_frame_length   <= LEN_ZERO;
         r_frame_overflow <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_pop) begin
            if (out_last) begin
               r_frame_done     <= 1'b1;
               r_frame_length   <= w_count_inc;
               r_frame_overflow <= r_sticky_ovf | w_at_max;
               r_byte_count     <= LEN_ZERO;
               r_sticky_ovf     <= 1'b0;
            end else begin
               r_byte_count <= w_count_inc;
               r_sticky_ovf <= r_sticky_ovf | w_at_max;
            end
         end else begin
            r_byte_count <= r_byte_count;
         end
      end
   end

   assign frame_done     = r_frame_done;
   assign frame_length   = r_frame_length;
   assign frame_overflow = r_frame_overflow;

endmodule

// File: tb/tb_fifo_frame_drain.sv
// Testbench for fifo_frame_drain: a queue-based upstream FIFO model, a
// directed vector table, hand-written corner sequences and randomized
// traffic checked against the frame rules (order, length, saturation).
module tb_fifo_frame_drain;

   localparam int DW  = 8;
   localparam int LW  = 11;
   localparam int LW4 = 4;
   localparam int MAX_LEN  = (1 << LW) - 1;
   localparam int MAX_LEN4 = (1 << LW4) - 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic [DW:0]   fifo_read_data = '0;
   logic          fifo_is_empty = 1'b1;
   logic          out_ready = 1'b0;

   logic          fifo_read_enable, out_last, out_valid, frame_done, frame_overflow;
   logic [DW-1:0] out_data;
   logic [LW-1:0] frame_length;

   logic          rden4, last4, valid4, done4, ovf4;
   logic [DW-1:0] data4;
   logic [LW4-1:0] len4;

   fifo_frame_drain #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) u_dut (
      .clock(clock), .reset_n(reset_n), .fifo_read_data(fifo_read_data),
      .fifo_is_empty(fifo_is_empty), .fifo_read_enable(fifo_read_enable),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready), .frame_done(frame_done),
      .frame_length(frame_length), .frame_overflow(frame_overflow));

   fifo_frame_drain #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW4)) u_dut4 (
      .clock(clock), .reset_n(reset_n), .fifo_read_data(fifo_read_data),
      .fifo_is_empty(fifo_is_empty), .fifo_read_enable(rden4),
      .out_data(data4), .out_last(last4), .out_valid(valid4),
      .out_ready(out_ready), .frame_done(done4),
      .frame_length(len4), .frame_overflow(ovf4));

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [DW:0]   src_q[$];
   logic [DW:0]   sent_q[$];
   logic [DW:0]   got_q[$];
   logic [LW:0]   done_q[$];
   logic [LW4:0]  done4_q[$];

   int            occ_model = 0;
   logic          prev_hold = 1'b0;
   logic [DW:0]   prev_word = '0;

   logic          s_rden, s_valid, s_last, s_done, s_ovf;
   logic [DW-1:0] s_data;
   logic [LW-1:0] s_len;

   typedef struct {
      logic          rden;
      logic          valid;
      logic [DW-1:0] data;
      logic          last;
      logic          done;
      logic [LW-1:0] len;
   } row_t;
   row_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load(input logic [DW:0] w);
      src_q.push_back(w);
      sent_q.push_back(w);
   endtask

   // One clock cycle: drive inputs, sample just after, model FIFO read latency.
   task automatic cycle(input logic stall, input logic rdy);
      logic rd_acc;
      logic pop;
      logic exp_rd;
      fifo_is_empty = (src_q.size() == 0) || stall;
      out_ready = rdy;
      #1;
      pop = out_valid & out_ready;
      exp_rd = !fifo_is_empty && ((occ_model < 2) || (occ_model == 2 && pop));
      chk("rd_enable", 32'(fifo_read_enable), 32'(exp_rd));
      if (prev_hold) chk("head_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_word}));
      prev_hold = out_valid & ~out_ready;
      prev_word = {out_last, out_data};
      s_rden = fifo_read_enable; s_valid = out_valid; s_data = out_data; s_last = out_last;
      s_done = frame_done; s_len = frame_length; s_ovf = frame_overflow;
      rd_acc = fifo_read_enable & ~fifo_is_empty;
      if (pop) got_q.push_back({out_last, out_data});
      if (frame_done) done_q.push_back({frame_overflow, frame_length});
      if (done4) done4_q.push_back({ovf4, len4});
      occ_model = occ_model + int'(rd_acc) - int'(pop);
      chk("occupancy_le2", 32'(occ_model <= 2), 32'd1);
      @(posedge clock);
      #1;
      if (rd_acc) fifo_read_data = src_q.pop_front();
   endtask

   task automatic drain(input int budget, input bit rnd);
      int c;
      int tail;
      c = 0;
      tail = 0;
      while (tail < 3 && c < budget) begin
         if (rnd) cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
         else     cycle(1'b0, 1'b1);
         c++;
         if (got_q.size() >= sent_q.size()) tail++;
      end
      chk("drain_budget", 32'(tail >= 3), 32'd1);
   endtask

   task automatic clear_q();
      src_q.delete(); sent_q.delete(); got_q.delete(); done_q.delete(); done4_q.delete();
   endtask

   // Compare delivered beats and frame reports against the words that were sent.
   task automatic check_stream();
      int n;
      int nf;
      int e_len;
      int e4_len;
      chk("beat_count", 32'(got_q.size()), 32'(sent_q.size()));
      for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
         chk("beat_word", 32'(got_q[i]), 32'(sent_q[i]));
      n = 0;
      nf = 0;
      foreach (sent_q[i]) begin
         n++;
         if (sent_q[i][DW]) begin
            e_len  = (n > MAX_LEN)  ? MAX_LEN  : n;
            e4_len = (n > MAX_LEN4) ? MAX_LEN4 : n;
            if (nf < done_q.size())
               chk("frame_ovf_len", 32'(done_q[nf]), 32'({n > MAX_LEN, LW'(e_len)}));
            else
               chk("frame_done_missing", 32'(done_q.size()), 32'(nf + 1));
            if (nf < done4_q.size())
               chk("frame4_ovf_len", 32'(done4_q[nf]), 32'({n > MAX_LEN4, LW4'(e4_len)}));
            else
               chk("frame4_done_missing", 32'(done4_q.size()), 32'(nf + 1));
            nf++;
            n = 0;
         end
      end
      chk("frame_count", 32'(done_q.size()), 32'(nf));
      chk("frame4_count", 32'(done4_q.size()), 32'(nf));
      clear_q();
   endtask

   // Hold reset for three cycles with the FIFO claiming data; every output must stay 0.
   task automatic do_reset();
      reset_n = 1'b0;
      clear_q();
      fifo_read_data = '0;
      fifo_is_empty = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("reset_outputs", 32'({fifo_read_enable, out_valid, out_data, out_last,
                                  frame_done, frame_length, frame_overflow}), 32'd0);
         chk("reset_outputs4", 32'({rden4, valid4, data4, last4, done4, len4, ovf4}), 32'd0);
         @(posedge clock);
         #1;
      end
      reset_n = 1'b1;
      occ_model = 0;
      prev_hold = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0};
      tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 11'd0};
      tbl[3] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 11'd0};
      tbl[4] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 11'd0};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 11'd3};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd3};

      #2;
      do_reset();

      // Test 1: three-word frame at full rate, cycle-exact vector table.
      load({1'b0, 8'h11}); load({1'b0, 8'h22}); load({1'b1, 8'h33});
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, 1'b1);
         chk("t1_rden", 32'(s_rden), 32'(tbl[i].rden));
         chk("t1_valid", 32'(s_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) chk("t1_data_last", 32'({s_last, s_data}), 32'({tbl[i].last, tbl[i].data}));
         chk("t1_done", 32'(s_done), 32'(tbl[i].done));
         chk("t1_len_ovf", 32'({s_ovf, s_len}), 32'({1'b0, tbl[i].len}));
      end
      check_stream();

      // Test 2: sink stalls for 5 cycles from the first beat; head held, no reads while full.
      load({1'b0, 8'h11}); load({1'b0, 8'h22}); load({1'b1, 8'h33});
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0);
         chk("t2_held", 32'({s_valid, s_last, s_data}), 32'({1'b1, 1'b0, 8'h11}));
         chk("t2_no_read", 32'(s_rden), 32'd0);
      end
      drain(50, 1'b0);
      check_stream();

      // Test 3: 64-byte frame under random FIFO gaps and sink backpressure.
      for (int i = 0; i < 64; i++) load({i == 63, 8'($urandom)});
      drain(3000, 1'b1);
      check_stream();

      // Test 4: back-to-back frames of 1 and 2 bytes; length holds afterwards.
      load({1'b1, 8'hA1}); load({1'b0, 8'hB1}); load({1'b1, 8'hB2});
      drain(50, 1'b0);
      check_stream();
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      chk("t4_len_hold", 32'({s_done, s_len}), 32'({1'b0, 11'd2}));

      // Test 5: 20-byte frame saturates the 4-bit counter, then a 2-byte frame.
      for (int i = 0; i < 20; i++) load({i == 19, 8'(i + 1)});
      load({1'b0, 8'hC1}); load({1'b1, 8'hC2});
      drain(200, 1'b0);
      check_stream();

      // Several random multi-frame bursts with varied lengths.
      for (int f = 0; f < 4; f++) begin
         int len;
         len = int'($urandom_range(1, 24));
         for (int i = 0; i < len; i++) load({i == len - 1, 8'($urandom)});
      end
      drain(2000, 1'b1);
      check_stream();

      // Test 6: reset with a read in flight mid-frame, then a fresh 3-byte frame.
      for (int i = 0; i < 5; i++) load({1'b0, 8'(8'h50 + i)});
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      do_reset();
      load({1'b0, 8'hD1}); load({1'b0, 8'hD2}); load({1'b1, 8'hD3});
      drain(50, 1'b0);
      check_stream();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
